// File: rtl/spi_slave_pkg.sv
// ============================================================================
// Module      : spi_slave_pkg
// Description : Shared types and constants for the SPI slave front end:
//               frame state encoding, receive/transmit sub-phases, default
//               word widths and the command codes carried in rx_data[9:8].
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package spi_slave_pkg;

    // Default widths: 2 command bits + 8 payload bits, 8-bit read byte.
    localparam int SPI_WORD_W = 10;
    localparam int SPI_DATA_W = 8;

    // Command codes found in the top two bits of each received word.
    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    // Frame-level state.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    // Progress inside a data state: receiving the word, waiting for the
    // read byte, shifting it out, or parked until the frame ends.
    typedef enum logic [1:0] {
        PH_RX    = 2'd0,
        RD_WAIT  = 2'd1,
        RD_SHIFT = 2'd2,
        PH_HOLD  = 2'd3
    } phase_t;

endpackage

`default_nettype wire

// File: rtl/spi_tx_shifter.sv
// ============================================================================
// Module      : spi_tx_shifter
// Description : Parallel-load, MSB-first serialiser driving MISO. The MSB
//               appears on the cycle after load, the remaining bits follow
//               one per cycle, then MISO returns low and done is raised.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module spi_tx_shifter
    import spi_slave_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] data,
    output logic              miso,
    output logic              done
);

    localparam int CNT_W = $clog2(DATA_W);

    // The MSB goes straight to MISO on load, so only the lower bits are held.
    logic [DATA_W-2:0] r_sr;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;

    // Load, shift-out and end-of-byte sequencing; clear drops MISO at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr   <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            miso   <= 1'b0;
            done   <= 1'b0;
        end else if (clear) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
            miso   <= 1'b0;
            done   <= 1'b0;
        end else if (load) begin
            r_sr   <= data[DATA_W-2:0];
            miso   <= data[DATA_W-1];
            r_cnt  <= CNT_W'(DATA_W - 1);
            r_busy <= 1'b1;
            done   <= 1'b0;
        end else if (r_busy) begin
            if (r_cnt == '0) begin
                miso   <= 1'b0;
                r_busy <= 1'b0;
                done   <= 1'b1;
            end else begin
                miso  <= r_sr[DATA_W-2];
                r_sr  <= {r_sr[DATA_W-3:0], 1'b0};
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/spi_slave_ctrl.sv
// ============================================================================
// Module      : spi_slave_ctrl
// Description : SPI slave serial front end. Deserialises one 10-bit word per
//               frame onto rx_data/rx_valid, remembers whether a read address
//               has been sent, and serialises the returned read byte on MISO.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module spi_slave_ctrl
    import spi_slave_pkg::*;
#(
    parameter int WORD_W = SPI_WORD_W,
    parameter int DATA_W = SPI_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid
);

    localparam int               CNT_W    = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

    state_t              r_state;
    phase_t              r_phase;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [WORD_W-2:0]   r_rx_sr;
    logic                r_rd_addr_received;
    logic                w_tx_load;
    logic                w_tx_done;

    // The read byte is accepted only while waiting for it inside a live frame.
    assign w_tx_load = !SS_n && (r_state == READ_DATA) && (r_phase == RD_WAIT) && tx_valid;

    // Frame sequencing, word capture and read-address tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state            <= IDLE;
            r_phase            <= PH_RX;
            r_bit_cnt          <= '0;
            r_rx_sr            <= '0;
            rx_data            <= '0;
            rx_valid           <= 1'b0;
            r_rd_addr_received <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (SS_n) begin
                // Deselect wins over everything, including a 10th bit.
                r_state   <= IDLE;
                r_phase   <= PH_RX;
                r_bit_cnt <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state   <= CHK_CMD;
                        r_phase   <= PH_RX;
                        r_bit_cnt <= '0;
                    end
                    CHK_CMD: begin
                        // Select bit steers the frame and is not part of the word.
                        if (!MOSI) begin
                            r_state <= WRITE;
                        end else if (r_rd_addr_received) begin
                            r_state <= READ_DATA;
                        end else begin
                            r_state <= READ_ADD;
                        end
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        if (r_phase == PH_RX) begin
                            r_rx_sr <= {r_rx_sr[WORD_W-3:0], MOSI};
                            if (r_bit_cnt == LAST_BIT) begin
                                rx_data   <= {r_rx_sr, MOSI};
                                rx_valid  <= 1'b1;
                                r_bit_cnt <= '0;
                                if (r_state == READ_DATA) begin
                                    r_rd_addr_received <= 1'b0;
                                    r_phase            <= RD_WAIT;
                                end else begin
                                    if (r_state == READ_ADD) begin
                                        r_rd_addr_received <= 1'b1;
                                    end
                                    r_phase <= PH_HOLD;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                            end
                        end else if (r_state == READ_DATA) begin
                            case (r_phase)
                                RD_WAIT:  if (tx_valid)  r_phase <= RD_SHIFT;
                                RD_SHIFT: if (w_tx_done) r_phase <= PH_HOLD;
                                default:  ;
                            endcase
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    spi_tx_shifter #(
        .DATA_W (DATA_W)
    ) u_tx_shifter (
        .clk   (clk),
        .rst   (rst),
        .clear (SS_n),
        .load  (w_tx_load),
        .data  (tx_data),
        .miso  (MISO),
        .done  (w_tx_done)
    );

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_ctrl.sv
// ============================================================================
// Module      : tb_spi_slave_ctrl
// Description : Self-checking bench for spi_slave_ctrl. A frame-level model
//               predicts rx_valid/rx_data/MISO every cycle; directed frames
//               add literal checks on words, latency and MISO byte order.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_spi_slave_ctrl;
    import spi_slave_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       SS_n = 1'b1;
    logic       MOSI = 1'b0;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;

    spi_slave_ctrl #(.WORD_W(10), .DATA_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    // k = number of edges in the current frame with SS_n low; edge 1 is the
    // select-detect edge, edge 2 the select bit, edges 3..12 the word bits.
    int         m_k = 0;
    logic       m_sel = 1'b0;
    logic [9:0] m_word = '0;
    int         m_mode = 0;      // 0 none, 1 write, 2 read-addr, 3 read-data
    bit         m_flag = 1'b0;
    bit         m_loaded = 1'b0;
    logic       m_valid = 1'b0;
    logic [9:0] m_data = '0;
    logic       m_miso = 1'b0;
    bit         mq[$];

    task model_step();
        if (rst) begin
            m_k = 0; m_flag = 1'b0; m_data = '0; m_valid = 1'b0;
            m_miso = 1'b0; m_loaded = 1'b0; m_mode = 0; mq.delete();
        end else if (SS_n) begin
            m_k = 0; m_valid = 1'b0; m_miso = 1'b0; m_loaded = 1'b0; mq.delete();
        end else begin
            m_k++;
            m_valid = 1'b0;
            if (m_k == 1) m_mode = 0;
            if (m_k == 2) m_sel = MOSI;
            if (m_k >= 3 && m_k <= 12) m_word = {m_word[8:0], MOSI};
            if (m_k == 12) begin
                m_valid = 1'b1;
                m_data  = m_word;
                if (!m_sel)      m_mode = 1;
                else if (m_flag) begin m_mode = 3; m_flag = 1'b0; end
                else             begin m_mode = 2; m_flag = 1'b1; end
            end
            if (m_k >= 13 && m_mode == 3 && !m_loaded && tx_valid) begin
                m_loaded = 1'b1;
                for (int b = 7; b >= 0; b--) mq.push_back(tx_data[b]);
            end
            m_miso = (mq.size() > 0) ? mq.pop_front() : 1'b0;
        end
    endtask

    always @(posedge clk) model_step();

    // Per-cycle comparison of every output against the model.
    always begin
        @(posedge clk);
        #1;
        chk("cyc_rx_valid", rx_valid, m_valid);
        chk("cyc_rx_data", rx_data, m_data);
        chk("cyc_miso", MISO, m_miso);
        if (rx_valid === 1'b1) pulses++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_frame(input logic sel);
        @(negedge clk); SS_n = 1'b0; MOSI = 1'($urandom);
        @(negedge clk); MOSI = sel;
    endtask

    task automatic send_bits(input logic [9:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); MOSI = w[9-i];
        end
    endtask

    task automatic end_frame();
        @(negedge clk); SS_n = 1'b1; MOSI = 1'b0;
    endtask

    task automatic hold_low(input int n);
        repeat (n) begin @(negedge clk); MOSI = 1'($urandom); end
    endtask

    // Full frame; returns rx_valid/rx_data sampled just after the 12th edge.
    task automatic full_frame(input logic sel, input logic [9:0] w,
                              output logic v, output logic [9:0] d);
        start_frame(sel);
        send_bits(w, 10);
        @(posedge clk); #1;
        v = rx_valid;
        d = rx_data;
    endtask

    task automatic capture(output logic [7:0] c);
        for (int i = 7; i >= 0; i--) begin
            @(posedge clk); #1; c[i] = MISO;
        end
    endtask

    task automatic miso_any(input int n, output logic a);
        a = 1'b0;
        repeat (n) begin @(posedge clk); #1; a = a | MISO; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       v;
        logic [9:0] d;
        logic [7:0] cap;
        logic       any;
        int         p0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_rx_data", rx_data, 10'h000);
        chk("rst_miso", MISO, 1'b0);
        @(negedge clk); rst = 1'b0;

        // Write address.
        p0 = pulses;
        full_frame(1'b0, {CMD_WR_ADDR, 8'h12}, v, d);
        chk("wa_pulse_edge12", v, 1'b1);
        chk("wa_data", d, 10'h012);
        hold_low(4);
        chk("wa_single_pulse", pulses - p0, 1);
        end_frame();

        // Write data.
        full_frame(1'b0, {CMD_WR_DATA, 8'hA5}, v, d);
        chk("wd_data", d, 10'h1A5);
        end_frame();

        // Read address: flag was clear, so tx_valid must be ignored.
        full_frame(1'b1, {CMD_RD_ADDR, 8'h12}, v, d);
        chk("ra_data", d, 10'h212);
        @(negedge clk); tx_valid = 1'b1; tx_data = 8'hFF;
        miso_any(10, any);
        chk("ra_no_miso", any, 1'b0);
        @(negedge clk); tx_valid = 1'b0;
        end_frame();

        // Read data, byte returned after the word.
        full_frame(1'b1, {CMD_RD_DATA, 8'h00}, v, d);
        chk("rd_data", d, 10'h300);
        @(negedge clk); tx_valid = 1'b1; tx_data = 8'hC3;
        capture(cap);
        chk("rd_miso_c3", cap, 8'hC3);
        @(posedge clk); #1;
        chk("rd_miso_tail", MISO, 1'b0);
        @(negedge clk); tx_valid = 1'b0;
        end_frame();

        // Abort after 6 bits, then abort on what would be the 10th bit.
        p0 = pulses;
        start_frame(1'b0); send_bits(10'h3FF, 6); end_frame();
        start_frame(1'b0); send_bits(10'h3FF, 9); end_frame();
        @(negedge clk);
        chk("abort_no_pulse", pulses - p0, 0);
        full_frame(1'b0, {CMD_WR_ADDR, 8'hF0}, v, d);
        chk("post_abort_pulse", v, 1'b1);
        chk("post_abort_data", d, 10'h0F0);
        end_frame();

        // Read-address flag survives an aborted frame.
        full_frame(1'b1, {CMD_RD_ADDR, 8'hAB}, v, d);
        chk("fp_ra_data", d, 10'h2AB);
        end_frame();
        start_frame(1'b1); send_bits(10'h3FF, 3); end_frame();
        @(negedge clk); tx_valid = 1'b1; tx_data = 8'h5A;
        full_frame(1'b1, {CMD_RD_DATA, 8'hCC}, v, d);
        chk("fp_rd_data", d, 10'h3CC);
        capture(cap);
        chk("fp_miso_5a", cap, 8'h5A);
        end_frame();
        @(negedge clk); tx_valid = 1'b0;

        // Reset in the middle of shifting out a read byte.
        full_frame(1'b1, {CMD_RD_ADDR, 8'h01}, v, d);
        end_frame();
        full_frame(1'b1, {CMD_RD_DATA, 8'hFF}, v, d);
        chk("rst_rd_data", d, 10'h3FF);
        @(negedge clk); tx_valid = 1'b1; tx_data = 8'hA5;
        @(posedge clk); #1; chk("rst_b7", MISO, 1'b1);
        @(negedge clk); tx_valid = 1'b0;
        @(posedge clk); #1; chk("rst_b6", MISO, 1'b0);
        @(posedge clk); #1; chk("rst_b5", MISO, 1'b1);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_miso", MISO, 1'b0);
        chk("midrst_valid", rx_valid, 1'b0);
        chk("midrst_data", rx_data, 10'h000);
        @(negedge clk); rst = 1'b0; SS_n = 1'b1; tx_valid = 1'b1; tx_data = 8'hFF;
        miso_any(5, any);
        chk("idle_tx_ignored", any, 1'b0);

        // Flag was cleared by reset: select=1 is a read-address frame again.
        full_frame(1'b1, {CMD_RD_ADDR, 8'h55}, v, d);
        chk("ar_ra_data", d, 10'h255);
        miso_any(10, any);
        chk("ar_ra_no_miso", any, 1'b0);
        end_frame();
        @(negedge clk); tx_data = 8'h3C;
        full_frame(1'b1, {CMD_RD_DATA, 8'h3C}, v, d);
        chk("ar_rd_data", d, 10'h33C);
        capture(cap);
        chk("ar_miso_3c", cap, 8'h3C);
        end_frame();
        @(negedge clk); tx_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
